video_ppi: RTL and testbench



---
 rtl/video_ppi_if.sv | 12 +
 rtl/video_ppi.sv | 177 +++++++++++++++++
 tb/tb_video_ppi.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_ppi_if.sv
// CPU I/O bus between the Z80/8080 core and the video PPI stage.
// The master drives the address, write data and strobes; the slave returns registered read data.
interface video_ppi_if;
    logic [7:0] io_addr;
    logic [7:0] io_din;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_dout;

    modport master (output io_addr, output io_din, output io_wr, output io_rd, input io_dout);
    modport slave  (input io_addr, input io_din, input io_wr, input io_rd, output io_dout);
endinterface

// File: rtl/video_ppi.sv
// Mode-0 8255-style PPI feeding scroll/border/mode512 to the display block,
// plus a palette-port write strobe retimed onto the 12 MHz pixel enable.
module video_ppi #(
    parameter int unsigned PAL_HOLD = 4,
    parameter logic [7:0]  PAL_PORT = 8'h0C
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_12mp,
    video_ppi_if.slave  io,
    input  logic [7:0]  pa_in,
    input  logic [7:0]  pb_in,
    input  logic [7:0]  pc_in,
    output logic [7:0]  pc_out,
    output logic [7:0]  scroll,
    output logic [3:0]  border,
    output logic        mode512,
    output logic        pal_we,
    output logic [7:0]  pal_data
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HOLD, S_GAP} pal_state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(PAL_HOLD - 1);

    logic [7:0] ctrl;
    logic [7:0] a_lat;
    logic [7:0] b_lat;
    logic [7:0] c_lat;
    logic [7:0] dout_q;
    logic       ppi_sel;
    logic       pal_wr;
    logic       a_in;
    logic       b_in;
    logic       cu_in;
    logic       cl_in;
    logic [7:0] a_pin;
    logic [7:0] b_pin;
    logic [7:0] c_pin;
    logic [7:0] rd_val;
    logic       ctrl_unused;

    pal_state_t state;
    pal_state_t state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic       we_n;
    logic [7:0] data_n;

    assign ppi_sel = (io.io_addr[7:2] == 6'd0);
    assign pal_wr  = io.io_wr && (io.io_addr == PAL_PORT);

    assign a_in  = ctrl[4];
    assign b_in  = ctrl[1];
    assign cu_in = ctrl[3];
    assign cl_in = ctrl[0];

    // Mode-select bits are retained in ctrl but never alter behaviour.
    assign ctrl_unused = ^{ctrl[7:5], ctrl[2]};

    assign a_pin = a_in ? 8'hFF : a_lat;
    assign b_pin = b_in ? 8'hFF : b_lat;
    assign c_pin = {cu_in ? 4'hF : c_lat[7:4], cl_in ? 4'hF : c_lat[3:0]};

    assign scroll     = a_pin;
    assign border     = b_pin[3:0];
    assign mode512    = b_pin[4];
    assign pc_out     = c_pin;
    assign io.io_dout = dout_q;

    always_comb begin
        rd_val = 8'hFF;
        unique case (io.io_addr[1:0])
            2'd0: rd_val = 8'hFF;
            2'd1: rd_val = {cu_in ? pc_in[7:4] : c_lat[7:4], cl_in ? pc_in[3:0] : c_lat[3:0]};
            2'd2: rd_val = b_in ? pb_in : b_lat;
            2'd3: rd_val = a_in ? pa_in : a_lat;
            default: rd_val = 8'hFF;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ctrl   <= 8'h9B;
            a_lat  <= '0;
            b_lat  <= '0;
            c_lat  <= '0;
            dout_q <= '0;
        end else begin
            if (io.io_wr && ppi_sel) begin
                unique case (io.io_addr[1:0])
                    2'd0: begin
                        if (io.io_din[7]) begin
                            ctrl  <= io.io_din;
                            a_lat <= '0;
                            b_lat <= '0;
                            c_lat <= '0;
                        end else begin
                            c_lat[io.io_din[3:1]] <= io.io_din[0];
                        end
                    end
                    2'd1: c_lat <= io.io_din;
                    2'd2: b_lat <= io.io_din;
                    2'd3: a_lat <= io.io_din;
                    default: ;
                endcase
            end
            if (io.io_rd && ppi_sel) begin
                dout_q <= rd_val;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pal_we   <= 1'b0;
            pal_data <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pal_we   <= we_n;
            pal_data <= data_n;
        end
    end

    // A write during HOLD cuts the strobe and forces one low pixel tick so the display sees a new edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we_n    = pal_we;
        data_n  = pal_data;
        unique case (state)
            S_IDLE: begin
                if (pal_wr) begin
                    data_n  = io.io_din;
                    state_n = S_ARM;
                end
            end
            S_ARM: begin
                if (pal_wr) begin
                    data_n = io.io_din;
                end
                if (ce_12mp) begin
                    we_n    = 1'b1;
                    cnt_n   = HOLD_LOAD;
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pal_wr) begin
                    data_n  = io.io_din;
                    we_n    = 1'b0;
                    state_n = S_GAP;
                end else if (ce_12mp) begin
                    if (cnt == 4'd0) begin
                        we_n    = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (pal_wr) begin
                    data_n = io.io_din;
                end
                if (ce_12mp) begin
                    state_n = S_ARM;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_video_ppi.sv
// Scoreboard bench for video_ppi: stimulus pushes expectations from a mask-based port model
// and a pixel-tick timeline model of the palette strobe; a monitor pops and compares.
module tb_video_ppi;

    localparam int unsigned PAL_HOLD = 4;
    localparam logic [7:0]  PAL_PORT = 8'h0C;

    logic       clk_sys;
    logic       reset_n;
    logic       ce_12mp;
    logic [7:0] pa_in;
    logic [7:0] pb_in;
    logic [7:0] pc_in;
    logic [7:0] pc_out;
    logic [7:0] scroll;
    logic [3:0] border;
    logic       mode512;
    logic       pal_we;
    logic [7:0] pal_data;

    video_ppi_if io();

    video_ppi #(.PAL_HOLD(PAL_HOLD), .PAL_PORT(PAL_PORT)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce_12mp  (ce_12mp),
        .io       (io),
        .pa_in    (pa_in),
        .pb_in    (pb_in),
        .pc_in    (pc_in),
        .pc_out   (pc_out),
        .scroll   (scroll),
        .border   (border),
        .mode512  (mode512),
        .pal_we   (pal_we),
        .pal_data (pal_data)
    );

    typedef struct {
        logic [7:0] scroll;
        logic [3:0] border;
        logic       mode512;
        logic [7:0] pc;
    } pins_t;

    typedef struct {
        logic [7:0] data;
        int         rise;
        int         hi;
        int         gap;
    } pal_t;

    pins_t      pin_q[$];
    logic [7:0] rd_q[$];
    pal_t       pal_q[$];

    int n_cmp;
    int n_bad;
    int cyc;
    int pal_free;

    logic [7:0] m_ctrl;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_c;
    logic [7:0] m_dout;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Pixel enable: sampled high at every clock edge whose index is 1 mod 4.
    initial begin
        cyc     = 0;
        ce_12mp = 1'b0;
        forever begin
            @(posedge clk_sys);
            cyc = cyc + 1;
            #1;
            ce_12mp = ((cyc % 4) == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) tick();
    endtask

    function automatic int next_ce(input int w);
        int e;
        e = w + 1;
        while ((e % 4) != 1) e = e + 1;
        return e;
    endfunction

    task automatic model_reset;
        m_ctrl = 8'h9B;
        m_a    = '0;
        m_b    = '0;
        m_c    = '0;
        m_dout = '0;
    endtask

    // Input sections are a mask: masked bits show the pull-up (pins) or the external input (reads).
    function automatic logic [7:0] port_view(input logic [1:0] p, input logic for_read);
        logic [7:0] lat;
        logic [7:0] ext;
        logic [7:0] inmask;
        case (p)
            2'd3: begin lat = m_a; ext = pa_in; inmask = {8{m_ctrl[4]}}; end
            2'd2: begin lat = m_b; ext = pb_in; inmask = {8{m_ctrl[1]}}; end
            2'd1: begin lat = m_c; ext = pc_in; inmask = {{4{m_ctrl[3]}}, {4{m_ctrl[0]}}}; end
            default: return 8'hFF;
        endcase
        return (lat & ~inmask) | ((for_read ? ext : 8'hFF) & inmask);
    endfunction

    function automatic pins_t exp_pins();
        pins_t p;
        logic [7:0] b;
        b         = port_view(2'd2, 1'b0);
        p.scroll  = port_view(2'd3, 1'b0);
        p.border  = b[3:0];
        p.mode512 = b[4];
        p.pc      = port_view(2'd1, 1'b0);
        return p;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (a < 8'd4) begin
            case (a[1:0])
                2'd0: begin
                    if (d[7]) begin
                        m_ctrl = d;
                        m_a = '0;
                        m_b = '0;
                        m_c = '0;
                    end else begin
                        m_c[d[3:1]] = d[0];
                    end
                end
                2'd1: m_c = d;
                2'd2: m_b = d;
                default: m_a = d;
            endcase
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        io.io_addr = a;
        io.io_din  = d;
        io.io_wr   = 1'b1;
        model_write(a, d);
        pin_q.push_back(exp_pins());
        tick();
        io.io_wr = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] a);
        io.io_addr = a;
        io.io_rd   = 1'b1;
        if (a < 8'd4) m_dout = port_view(a[1:0], 1'b1);
        rd_q.push_back(m_dout);
        tick();
        io.io_rd = 1'b0;
    endtask

    task automatic pal_write_idle(input logic [7:0] d);
        int r;
        r = next_ce(cyc + 1);
        pal_q.push_back('{data: d, rise: r, hi: int'(PAL_HOLD), gap: -1});
        io_write(PAL_PORT, d);
        pal_free = r + 4 * int'(PAL_HOLD);
    endtask

    task automatic check_pins_now(input string nm);
        pins_t p;
        p = exp_pins();
        chk(nm, {scroll, border, mode512, pc_out}, {p.scroll, p.border, p.mode512, p.pc});
    endtask

    initial begin
        logic rd_s;
        logic wr_s;
        logic ce_s;
        logic prev_we;
        logic have;
        logic data_bad;
        int   hi;
        int   gap;
        pal_t cur;
        pins_t p;
        prev_we  = 1'b0;
        have     = 1'b0;
        data_bad = 1'b0;
        hi       = 0;
        gap      = 0;
        forever begin
            @(posedge clk_sys);
            rd_s = io.io_rd;
            wr_s = io.io_wr;
            ce_s = ce_12mp;
            @(negedge clk_sys);
            if (rd_s) begin
                if (rd_q.size() == 0) fail("io_dout: read with no expectation queued");
                else chk("io_dout", io.io_dout, rd_q.pop_front());
            end
            if (wr_s) begin
                if (pin_q.size() == 0) fail("pins: write with no expectation queued");
                else begin
                    p = pin_q.pop_front();
                    chk("pins{scroll,border,mode512,pc_out}", {scroll, border, mode512, pc_out},
                        {p.scroll, p.border, p.mode512, p.pc});
                end
            end
            if (prev_we && ce_s) hi = hi + 1;
            if (!prev_we && pal_we) begin
                if (pal_q.size() == 0) fail("pal_we: unexpected strobe rise");
                else begin
                    cur  = pal_q.pop_front();
                    have = 1'b1;
                    chk("pal_rise_cycle", cyc, cur.rise);
                    chk("pal_data_at_rise", pal_data, cur.data);
                    if (cur.gap >= 0) chk("pal_gap_ticks", gap, cur.gap);
                end
                hi       = 0;
                data_bad = 1'b0;
            end else if (prev_we && pal_we) begin
                if (have && (pal_data !== cur.data)) data_bad = 1'b1;
            end else if (prev_we && !pal_we) begin
                if (have) begin
                    chk("pal_hi_ticks", hi, cur.hi);
                    chk("pal_data_stable", data_bad, 1'b0);
                end
                have = 1'b0;
                gap  = 0;
            end else if (ce_s) begin
                gap = gap + 1;
            end
            prev_we = pal_we;
        end
    end

    initial begin
        int w;
        int r;
        int op;
        logic [7:0] a;
        n_cmp      = 0;
        n_bad      = 0;
        pal_free   = 0;
        reset_n    = 1'b0;
        io.io_addr = '0;
        io.io_din  = '0;
        io.io_wr   = 1'b0;
        io.io_rd   = 1'b0;
        pa_in      = '0;
        pb_in      = '0;
        pc_in      = '0;
        model_reset();
        repeat (4) tick();
        reset_n = 1'b1;
        tick();

        check_pins_now("reset_pins");
        chk("reset_pal_we", pal_we, 1'b0);
        chk("reset_pal_data", pal_data, 8'h00);
        chk("reset_io_dout", io.io_dout, 8'h00);
        pc_in = 8'h5A;
        io_read(8'd1);

        io_write(8'd0, 8'h80);
        io_write(8'd3, 8'h2A);
        io_write(8'd2, 8'h15);
        io_read(8'd3);
        io_read(8'd2);

        io_write(8'd1, 8'h00);
        io_write(8'd0, 8'h07);
        io_write(8'd0, 8'h06);
        io_read(8'd0);

        io_write(8'd0, 8'h88);
        io_write(8'd1, 8'h3C);
        pc_in = 8'hA5;
        io_read(8'd1);

        // Palette write landing on a pixel tick: strobe must wait for the following tick.
        while ((cyc % 4) != 0) tick();
        pal_write_idle(8'h47);
        wait_until(pal_free + 2);
        io_write(8'h0D, 8'h33);
        repeat (20) tick();

        // Two writes while armed: one strobe carrying the later data.
        while ((cyc % 4) != 1) tick();
        r = next_ce(cyc + 1);
        pal_q.push_back('{data: 8'h22, rise: r, hi: int'(PAL_HOLD), gap: -1});
        io_write(PAL_PORT, 8'h11);
        io_write(PAL_PORT, 8'h22);
        wait_until(r + 4 * int'(PAL_HOLD) + 3);

        // Write during HOLD after two high ticks: cut, one low tick, then a full strobe.
        while ((cyc % 4) != 2) tick();
        w = cyc + 1;
        r = next_ce(w);
        pal_q.push_back('{data: 8'h47, rise: r, hi: 2, gap: -1});
        io_write(PAL_PORT, 8'h47);
        wait_until(r + 8);
        pal_q.push_back('{data: 8'h99, rise: r + 16, hi: int'(PAL_HOLD), gap: 1});
        io_write(PAL_PORT, 8'h99);
        wait_until(r + 16 + 4 * int'(PAL_HOLD) + 3);

        // Asynchronous reset in the middle of a strobe.
        while ((cyc % 4) != 2) tick();
        r = next_ce(cyc + 1);
        pal_q.push_back('{data: 8'h55, rise: r, hi: 1, gap: -1});
        io_write(PAL_PORT, 8'h55);
        wait_until(r + 5);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_pal_we", pal_we, 1'b0);
        chk("async_reset_pal_data", pal_data, 8'h00);
        chk("async_reset_io_dout", io.io_dout, 8'h00);
        check_pins_now("async_reset_pins");
        tick();
        reset_n = 1'b1;
        repeat (30) tick();
        pal_write_idle(8'h3C);
        wait_until(pal_free + 2);

        for (int i = 0; i < 300; i++) begin
            pa_in = 8'($urandom);
            pb_in = 8'($urandom);
            pc_in = 8'($urandom);
            op = int'($urandom_range(0, 7));
            case (op)
                0: io_write(8'd0, 8'h80 | 8'($urandom_range(0, 127)));
                1: io_write(8'd0, 8'($urandom_range(0, 127)));
                2, 3: io_write(8'($urandom_range(1, 3)), 8'($urandom));
                4, 5: io_read(8'($urandom_range(0, 3)));
                6: begin
                    a = 8'($urandom_range(4, 255));
                    if (a == PAL_PORT) a = 8'h0D;
                    if ($urandom_range(0, 1) == 0) io_write(a, 8'($urandom));
                    else io_read(a);
                end
                default: begin
                    if (cyc >= pal_free) pal_write_idle(8'($urandom));
                    else tick();
                end
            endcase
        end

        repeat (40) tick();
        chk("pal_q_drained", pal_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("pin_q_drained", pin_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
